// File: rtl/regfile_pkg.sv
// Shared definitions for the scoreboarded register file: default sizes,
// ABI register indices and the 5-bit architectural register address type.
package regfile_pkg;

   localparam int XLEN_DEF  = 32;
   localparam int NREGS_DEF = 32;

   localparam int REG_ZERO = 0;
   localparam int REG_RA   = 1;
   localparam int REG_SP   = 2;
   localparam int REG_GP   = 3;
   localparam int REG_TP   = 4;
   localparam int REG_A0   = 10;

   typedef logic [4:0] reg_addr_t;

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register busy bits: issue sets, writeback clears, flush clears all.
// Register 0 can never be marked busy.
module reg_scoreboard
   import regfile_pkg::*;
#(
   parameter int  NREGS = NREGS_DEF,
   localparam int AW    = $clog2(NREGS)
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             clr_en,
   input  logic [AW-1:0]    clr_addr,
   input  logic             iss_valid,
   input  logic [AW-1:0]    iss_rd,
   input  logic             flush,
   output logic             iss_ready,
   output logic [NREGS-1:0] busy_vec
);

   logic [NREGS-1:0] r_busy;
   logic [NREGS-1:0] w_set;
   logic [NREGS-1:0] w_clr;
   logic [NREGS-1:0] w_busy_nxt;

   // A claim on an already-busy destination is refused to block WAW hazards.
   assign iss_ready = !flush && ((iss_rd == '0) || !r_busy[iss_rd]);
   assign busy_vec  = r_busy;

   always_comb begin
      w_set = '0;
      w_clr = '0;
      if (iss_valid && iss_ready && (iss_rd != '0))
         w_set[iss_rd] = 1'b1;
      if (clr_en && (clr_addr != '0))
         w_clr[clr_addr] = 1'b1;
      // Set is applied after clear so a same-cycle claim keeps the bit busy.
      w_busy_nxt    = flush ? '0 : (w_set | (r_busy & ~w_clr));
      w_busy_nxt[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (!reset_n)
         r_busy <= '0;
      else
         r_busy <= w_busy_nxt;
   end

endmodule

// File: rtl/register_file_sb.sv
// Register file with NUM_RD combinational read ports, one write port and a
// busy scoreboard. Define REGFILE_BYPASS_EN for same-cycle write-to-read forwarding.
module register_file_sb
   import regfile_pkg::*;
#(
   parameter int  XLEN   = XLEN_DEF,
   parameter int  NREGS  = NREGS_DEF,
   parameter int  NUM_RD = 2,
   localparam int AW     = $clog2(NREGS)
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic [NUM_RD*AW-1:0]   rd_addr,
   output logic [NUM_RD*XLEN-1:0] rd_data,
   output logic [NUM_RD-1:0]      rd_busy,
   input  logic                   reg_wren,
   input  logic [AW-1:0]          write_address,
   input  logic [XLEN-1:0]        write_data,
   input  logic                   iss_valid,
   input  logic [AW-1:0]          iss_rd,
   output logic                   iss_ready,
   input  logic                   flush,
   output logic [NREGS-1:0]       busy_vec
);

   logic [XLEN-1:0]  r_regs [NREGS];
   logic             w_wr_en;
   logic             w_iss_ready;
   logic [NREGS-1:0] w_busy_vec;

   assign w_wr_en   = reg_wren && (write_address != '0);
   assign iss_ready = w_iss_ready;
   assign busy_vec  = w_busy_vec;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         for (int k = 0; k < NREGS; k++)
            r_regs[k] <= '0;
      end else if (w_wr_en) begin
         r_regs[write_address] <= write_data;
      end
   end

   reg_scoreboard #(
      .NREGS (NREGS)
   ) u_sb (
      .clk       (clk),
      .reset_n   (reset_n),
      .clr_en    (w_wr_en),
      .clr_addr  (write_address),
      .iss_valid (iss_valid),
      .iss_rd    (iss_rd),
      .flush     (flush),
      .iss_ready (w_iss_ready),
      .busy_vec  (w_busy_vec)
   );

   for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
      logic [AW-1:0] w_addr;
      assign w_addr = rd_addr[gi*AW +: AW];
`ifdef REGFILE_BYPASS_EN
      logic w_hit;
      logic w_claim;
      assign w_hit   = w_wr_en && (w_addr == write_address);
      // A forwarded register stays busy only if it is re-claimed this cycle.
      assign w_claim = iss_valid && w_iss_ready && (iss_rd == w_addr);
      assign rd_data[gi*XLEN +: XLEN] = (w_addr == '0) ? '0 :
                                        w_hit ? write_data : r_regs[w_addr];
      assign rd_busy[gi] = w_hit ? w_claim : w_busy_vec[w_addr];
`else
      assign rd_data[gi*XLEN +: XLEN] = (w_addr == '0) ? '0 : r_regs[w_addr];
      assign rd_busy[gi] = w_busy_vec[w_addr];
`endif
   end

endmodule

// File: tb/tb_register_file_sb.sv
// Table-driven bench for register_file_sb with an expectation queue;
// expectations follow REGFILE_BYPASS_EN when it is defined.
module tb_register_file_sb;
   import regfile_pkg::*;

`ifdef REGFILE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic        clk;
   logic        reset_n;
   logic [9:0]  rd_addr;
   logic [63:0] rd_data;
   logic [1:0]  rd_busy;
   logic        reg_wren;
   logic [4:0]  write_address;
   logic [31:0] write_data;
   logic        iss_valid;
   logic [4:0]  iss_rd;
   logic        iss_ready;
   logic        flush;
   logic [31:0] busy_vec;

   register_file_sb dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .rd_addr       (rd_addr),
      .rd_data       (rd_data),
      .rd_busy       (rd_busy),
      .reg_wren      (reg_wren),
      .write_address (write_address),
      .write_data    (write_data),
      .iss_valid     (iss_valid),
      .iss_rd        (iss_rd),
      .iss_ready     (iss_ready),
      .flush         (flush),
      .busy_vec      (busy_vec)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        rst_n;
      logic        wren;
      logic [4:0]  waddr;
      logic [31:0] wdata;
      logic        iv;
      logic [4:0]  ird;
      logic        fl;
      logic [4:0]  ra0;
      logic [4:0]  ra1;
      logic [31:0] d0;
      logic [31:0] d1;
      logic [1:0]  b;
      logic [31:0] bv;
      logic        rdy;
   } vec_t;

   typedef struct {
      string       tag;
      logic [31:0] d0;
      logic [31:0] d1;
      logic [1:0]  b;
      logic [31:0] bv;
      logic        rdy;
   } exp_t;

   int   checks = 0;
   int   errors = 0;
   exp_t exp_q[$];
   vec_t tbl[19];

   function automatic vec_t mk(input logic rst_n, input logic wren,
                               input logic [4:0] waddr, input logic [31:0] wdata,
                               input logic iv, input logic [4:0] ird, input logic fl,
                               input logic [4:0] ra0, input logic [4:0] ra1,
                               input logic [31:0] d0, input logic [31:0] d1,
                               input logic [1:0] b, input logic [31:0] bv,
                               input logic rdy);
      vec_t v;
      v.rst_n = rst_n; v.wren = wren; v.waddr = waddr; v.wdata = wdata;
      v.iv = iv; v.ird = ird; v.fl = fl; v.ra0 = ra0; v.ra1 = ra1;
      v.d0 = d0; v.d1 = d1; v.b = b; v.bv = bv; v.rdy = rdy;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic compare_front();
      exp_t e;
      if (exp_q.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL queue: got empty expected an entry");
         return;
      end
      e = exp_q.pop_front();
      chk({e.tag, ".rd_data0"}, rd_data[31:0], e.d0);
      chk({e.tag, ".rd_data1"}, rd_data[63:32], e.d1);
      chk({e.tag, ".rd_busy"}, {30'd0, rd_busy}, {30'd0, e.b});
      chk({e.tag, ".busy_vec"}, busy_vec, e.bv);
      chk({e.tag, ".iss_ready"}, {31'd0, iss_ready}, {31'd0, e.rdy});
   endtask

   task automatic apply(input vec_t v, input string tag);
      exp_t e;
      @(posedge clk);
      #1;
      reset_n       = v.rst_n;
      reg_wren      = v.wren;
      write_address = v.waddr;
      write_data    = v.wdata;
      iss_valid     = v.iv;
      iss_rd        = v.ird;
      flush         = v.fl;
      rd_addr       = {v.ra1, v.ra0};
      e.tag = tag; e.d0 = v.d0; e.d1 = v.d1; e.b = v.b; e.bv = v.bv; e.rdy = v.rdy;
      exp_q.push_back(e);
      @(negedge clk);
      compare_front();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // Write 5, drop write to 0, claim/refuse/clear 7, set-wins on 9, flush,
      // forwarding on 12, reset mid-flight with 4 and 6 busy.
      tbl[0]  = mk(1,1,5,32'hDEADBEEF,0,0,0, 5,0, BYP ? 32'hDEADBEEF : 32'h0, 0, 2'b00, 0, 1);
      tbl[1]  = mk(1,1,0,32'h12345678,0,0,0, 5,0, 32'hDEADBEEF, 0, 2'b00, 0, 1);
      tbl[2]  = mk(1,0,0,0,0,0,0, 5,0, 32'hDEADBEEF, 0, 2'b00, 0, 1);
      tbl[3]  = mk(1,0,0,0,1,7,0, 7,5, 0, 32'hDEADBEEF, 2'b00, 0, 1);
      tbl[4]  = mk(1,0,0,0,1,7,0, 7,7, 0, 0, 2'b11, 32'd1 << 7, 0);
      tbl[5]  = mk(1,1,7,32'hA5,0,0,0, 7,5, BYP ? 32'hA5 : 32'h0, 32'hDEADBEEF,
                   BYP ? 2'b00 : 2'b01, 32'd1 << 7, 1);
      tbl[6]  = mk(1,0,0,0,0,0,0, 7,7, 32'hA5, 32'hA5, 2'b00, 0, 1);
      tbl[7]  = mk(1,1,9,32'h55,1,9,0, 9,9, BYP ? 32'h55 : 32'h0, BYP ? 32'h55 : 32'h0,
                   BYP ? 2'b11 : 2'b00, 0, 1);
      tbl[8]  = mk(1,0,0,0,0,0,0, 9,9, 32'h55, 32'h55, 2'b11, 32'd1 << 9, 1);
      tbl[9]  = mk(1,0,0,0,1,3,1, 9,3, 32'h55, 0, 2'b01, 32'd1 << 9, 0);
      tbl[10] = mk(1,0,0,0,0,0,0, 3,9, 0, 32'h55, 2'b00, 0, 1);
      tbl[11] = mk(1,0,0,0,1,12,0, 12,12, 0, 0, 2'b00, 0, 1);
      tbl[12] = mk(1,1,12,32'h77,0,0,0, 12,12, BYP ? 32'h77 : 32'h0, BYP ? 32'h77 : 32'h0,
                   BYP ? 2'b00 : 2'b11, 32'd1 << 12, 1);
      tbl[13] = mk(1,0,0,0,0,0,0, 12,12, 32'h77, 32'h77, 2'b00, 0, 1);
      tbl[14] = mk(1,0,0,0,1,REG_TP[4:0],0, 4,6, 0, 0, 2'b00, 0, 1);
      tbl[15] = mk(1,0,0,0,1,6,0, 4,6, 0, 0, 2'b01, 32'd1 << 4, 1);
      tbl[16] = mk(0,1,5,32'hBAD,1,8,0, 4,6, 0, 0, 2'b11, (32'd1 << 4) | (32'd1 << 6), 1);
      tbl[17] = mk(1,0,0,0,0,0,0, 5,7, 0, 0, 2'b00, 0, 1);
      tbl[18] = mk(1,0,0,0,0,0,0, 5,9, 0, 0, 2'b00, 0, 1);

      reset_n = 1'b0; reg_wren = 1'b0; write_address = '0; write_data = '0;
      iss_valid = 1'b0; iss_rd = '0; flush = 1'b0; rd_addr = '0;
      repeat (2) @(posedge clk);

      // Every address on both ports reads zero and not busy after reset.
      for (int a = 0; a < 32; a++)
         apply(mk(1,0,0,0,0,0,0, a[4:0], 5'(31 - a), 0, 0, 2'b00, 0, 1),
               $sformatf("rst_rd%0d", a));

      for (int i = 0; i < 19; i++)
         apply(tbl[i], $sformatf("row%0d", i));

      // Ports naming the same written register agree.
      apply(mk(1,1,REG_A0[4:0],32'hCAFEF00D,0,0,0, 10,10,
               BYP ? 32'hCAFEF00D : 32'h0, BYP ? 32'hCAFEF00D : 32'h0, 2'b00, 0, 1), "a0_wr");
      apply(mk(1,0,0,0,0,0,0, 10,10, 32'hCAFEF00D, 32'hCAFEF00D, 2'b00, 0, 1), "a0_rd");

      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL queue_drain: got %0d expected 0", exp_q.size());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
